commit_unit: RTL

Parametrised in-order commit/writeback stage for the fine-grained multithreaded core. It sits after the TLB/memory stage and decides per instruction whether to commit, replay or drop, tracked by a per-thread expected PC. On commit it drives the fetch PC per thread, a registered register-file write port and a store queue that drains to the d-cache. It also stalls fetch while the store queue is full and keeps a retired-instruction counter per thread.

---
 rtl/commit_unit.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/commit_unit.sv
// In-order commit/writeback stage: per-thread expected-PC tracking decides commit/replay/drop,
// drives fetch PCs, a registered register-file write port and an in-order store queue to the d-cache.
module commit_unit #(
    parameter int N_THREADS = 8,
    parameter int XLEN = 32,
    parameter int N_REGS = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h1000,
    parameter int SQ_DEPTH = 4,
    parameter int CNT_W = 32,
    localparam int TID_W = $clog2(N_THREADS),
    localparam int REG_W = $clog2(N_REGS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wb_valid,
    input  logic [TID_W-1:0]           wb_thread,
    input  logic                       wb_isvalid,
    input  logic [XLEN-1:0]            wb_pc,
    input  logic [REG_W-1:0]           wb_dst,
    input  logic [XLEN-1:0]            wb_data,
    input  logic [XLEN-1:0]            wb_mul,
    input  logic                       wb_isequal,
    input  logic                       wb_flag_reg,
    input  logic                       wb_flag_mul,
    input  logic                       wb_flag_jump,
    input  logic                       wb_flag_branch,
    input  logic                       wb_flag_store,
    input  logic                       wb_flag_isbyte,
    input  logic [XLEN-1:0]            wb_st_addr,
    input  logic [XLEN-1:0]            wb_st_data,
    output logic [N_THREADS*XLEN-1:0]  pc_out,
    output logic [N_THREADS-1:0]       stalled,
    output logic                       rf_wen,
    output logic [TID_W-1:0]           rf_thread,
    output logic [REG_W-1:0]           rf_addr,
    output logic [XLEN-1:0]            rf_data,
    output logic                       st_valid,
    input  logic                       st_ready,
    output logic                       st_isbyte,
    output logic [XLEN-1:0]            st_addr,
    output logic [XLEN-1:0]            st_data,
    output logic [N_THREADS*CNT_W-1:0] retired
);

    localparam int PTR_W = $clog2(SQ_DEPTH);
    localparam int SQC_W = $clog2(SQ_DEPTH + 1);
    localparam logic [SQC_W-1:0] SQ_FULL_CNT = SQC_W'(SQ_DEPTH);

    logic [XLEN-1:0]  pc_q     [N_THREADS];
    logic [XLEN-1:0]  exp_pc_q [N_THREADS];
    logic [CNT_W-1:0] ret_q    [N_THREADS];

    logic             rf_wen_q;
    logic [TID_W-1:0] rf_thread_q;
    logic [REG_W-1:0] rf_addr_q;
    logic [XLEN-1:0]  rf_data_q;

    logic             sq_isbyte_q [SQ_DEPTH];
    logic [XLEN-1:0]  sq_addr_q   [SQ_DEPTH];
    logic [XLEN-1:0]  sq_data_q   [SQ_DEPTH];
    logic [PTR_W-1:0] head_q, tail_q;
    logic [SQC_W-1:0] count_q, count_d;

    logic            match, sq_full, commit, replay, taken, push, pop, rf_write;
    logic [XLEN-1:0] next_pc_d;

    // Fullness comes from the registered count, so a pop this cycle never makes room for a push.
    always_comb begin
        sq_full   = (count_q == SQ_FULL_CNT);
        match     = wb_valid && (wb_pc == exp_pc_q[wb_thread]);
        commit    = match && wb_isvalid && !(wb_flag_store && sq_full);
        replay    = match && !commit;
        taken     = wb_flag_jump && (!wb_flag_branch || wb_isequal);
        next_pc_d = taken ? wb_data : exp_pc_q[wb_thread] + XLEN'(4);
        rf_write  = commit && wb_flag_reg && (wb_dst != '0);
        push      = commit && wb_flag_store;
        pop       = (count_q != '0) && st_ready;
        count_d   = count_q;
        if (push && !pop) begin
            count_d = count_q + SQC_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - SQC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < N_THREADS; t++) begin
                pc_q[t]     <= RESET_PC;
                exp_pc_q[t] <= RESET_PC;
                ret_q[t]    <= '0;
            end
            for (int e = 0; e < SQ_DEPTH; e++) begin
                sq_isbyte_q[e] <= 1'b0;
                sq_addr_q[e]   <= '0;
                sq_data_q[e]   <= '0;
            end
            rf_wen_q    <= 1'b0;
            rf_thread_q <= '0;
            rf_addr_q   <= '0;
            rf_data_q   <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
        end else begin
            if (commit) begin
                pc_q[wb_thread]     <= next_pc_d;
                exp_pc_q[wb_thread] <= next_pc_d;
                ret_q[wb_thread]    <= ret_q[wb_thread] + CNT_W'(1);
            end else if (replay) begin
                pc_q[wb_thread] <= exp_pc_q[wb_thread];
            end
            rf_wen_q <= rf_write;
            if (rf_write) begin
                rf_thread_q <= wb_thread;
                rf_addr_q   <= wb_dst;
                rf_data_q   <= wb_flag_mul ? wb_mul : wb_data;
            end
            if (push) begin
                sq_isbyte_q[tail_q] <= wb_flag_isbyte;
                sq_addr_q[tail_q]   <= wb_st_addr;
                sq_data_q[tail_q]   <= wb_st_data;
                tail_q              <= tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_q <= head_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    for (genvar g = 0; g < N_THREADS; g++) begin : g_thread_out
        assign pc_out[g*XLEN +: XLEN]    = pc_q[g];
        assign retired[g*CNT_W +: CNT_W] = ret_q[g];
    end

    assign stalled   = {N_THREADS{sq_full}};
    assign rf_wen    = rf_wen_q;
    assign rf_thread = rf_thread_q;
    assign rf_addr   = rf_addr_q;
    assign rf_data   = rf_data_q;
    assign st_valid  = (count_q != '0);
    assign st_isbyte = sq_isbyte_q[head_q];
    assign st_addr   = sq_addr_q[head_q];
    assign st_data   = sq_data_q[head_q];

endmodule
